srl_rule_writer: RTL and testbench

- Update-path driver that serially loads a TCAM rule into one column of eight SRL32 slices (shared serial data line, per-slice clock enable).
- Each slice decodes 5 key bits. SRL bit at address a is 1 iff a matches that slice's key/mask.
- Sits between the rule-update interface (host/control plane) and the SRL storage column. It converts one key/mask rule into NSLICE×32 shift cycles, or into a 32-cycle erase.

---
 rtl/srl_rule_writer_if.sv | 24 ++
 rtl/srl_rule_writer.sv | 117 +++++++++++
 tb/tb_srl_rule_writer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/srl_rule_writer_if.sv
// Rule-update handshake and SRL column drive bundle for srl_rule_writer.
// The host side uses the master modport and the writer uses the slave modport.
interface srl_rule_writer_if #(
    parameter int NSLICE = 8
);
    logic                upd_valid;
    logic                upd_ready;
    logic                upd_op;
    logic [5*NSLICE-1:0] upd_key;
    logic [5*NSLICE-1:0] upd_mask;
    logic                upd_done;
    logic                srl_d;
    logic [NSLICE-1:0]   srl_ce;

    modport master (
        output upd_valid, upd_op, upd_key, upd_mask,
        input  upd_ready, upd_done, srl_d, srl_ce
    );

    modport slave (
        input  upd_valid, upd_op, upd_key, upd_mask,
        output upd_ready, upd_done, srl_d, srl_ce
    );
endinterface

// File: rtl/srl_rule_writer.sv
// Serially loads one key/mask TCAM rule, or an erase, into a column of SRL32 slices.
// All outputs are registered from the next-state/next-counter values, so ce appears the cycle after acceptance.
module srl_rule_writer #(
    parameter int NSLICE = 8,
    parameter int DEPTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    srl_rule_writer_if.slave bus
);
    localparam int              KW     = 5 * NSLICE;
    localparam int              SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [4:0]      A_TOP  = 5'(DEPTH - 1);
    localparam logic [SW-1:0]   S_LAST = SW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ERASE, DONE} state_t;

    state_t            state_p0, state_nx;
    logic [SW-1:0]     s_p0, s_nx;
    logic [4:0]        a_p0, a_nx;
    logic [KW-1:0]     key_p0, mask_p0;
    logic [KW-1:0]     key_sel, mask_sel;
    logic              d_nx, done_nx, ready_nx;
    logic [NSLICE-1:0] ce_nx;
    logic              srl_d_p1, upd_done_p1, upd_ready_p1;
    logic [NSLICE-1:0] srl_ce_p1;

    function automatic logic slice_match(input logic [4:0] a, input logic [4:0] k,
                                         input logic [4:0] m);
        return ((a ^ k) & ~m) == 5'd0;
    endfunction

    // Stage p0: control state and counters; p1: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0     <= IDLE;
            s_p0         <= '0;
            a_p0         <= '0;
            srl_d_p1     <= 1'b0;
            srl_ce_p1    <= '0;
            upd_done_p1  <= 1'b0;
            upd_ready_p1 <= 1'b1;
        end else begin
            state_p0     <= state_nx;
            s_p0         <= s_nx;
            a_p0         <= a_nx;
            srl_d_p1     <= d_nx;
            srl_ce_p1    <= ce_nx;
            upd_done_p1  <= done_nx;
            upd_ready_p1 <= ready_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (state_p0 == IDLE && bus.upd_valid) begin
            key_p0  <= bus.upd_key;
            mask_p0 <= bus.upd_mask;
        end
    end

    always_comb begin
        state_nx = state_p0;
        s_nx     = s_p0;
        a_nx     = a_p0;
        case (state_p0)
            IDLE: begin
                if (bus.upd_valid) begin
                    state_nx = bus.upd_op ? ERASE : LOAD;
                    s_nx     = '0;
                    a_nx     = A_TOP;
                end
            end
            LOAD: begin
                if (a_p0 == 5'd0) begin
                    if (s_p0 == S_LAST) begin
                        state_nx = DONE;
                    end else begin
                        s_nx = s_p0 + 1'b1;
                        a_nx = A_TOP;
                    end
                end else begin
                    a_nx = a_p0 - 1'b1;
                end
            end
            ERASE: begin
                if (a_p0 == 5'd0) state_nx = DONE;
                else              a_nx = a_p0 - 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The first shifted bit is computed on the acceptance edge, before key_p0 is loaded
    assign key_sel  = (state_p0 == IDLE) ? bus.upd_key  : key_p0;
    assign mask_sel = (state_p0 == IDLE) ? bus.upd_mask : mask_p0;

    always_comb begin
        ce_nx    = '0;
        d_nx     = 1'b0;
        done_nx  = (state_nx == DONE);
        ready_nx = (state_nx == IDLE);
        case (state_nx)
            LOAD: begin
                ce_nx = NSLICE'(1) << s_nx;
                d_nx  = slice_match(a_nx, key_sel[5*s_nx +: 5], mask_sel[5*s_nx +: 5]);
            end
            ERASE:   ce_nx = '1;
            default: ce_nx = '0;
        endcase
    end

    assign bus.srl_d     = srl_d_p1;
    assign bus.srl_ce    = srl_ce_p1;
    assign bus.upd_done  = upd_done_p1;
    assign bus.upd_ready = upd_ready_p1;
endmodule

// File: tb/tb_srl_rule_writer.sv
// Bench for srl_rule_writer: shifts a model SRL column from srl_d/srl_ce and compares
// its contents, timing and handshake against constants and a rule-level reference.
module tb_srl_rule_writer;
    localparam int NS = 8;
    localparam int KW = 5 * NS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    srl_rule_writer_if #(.NSLICE(NS)) bus ();
    srl_rule_writer #(.NSLICE(NS), .DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic                op;
        logic [KW-1:0]       key;
        logic [KW-1:0]       mask;
        logic [NS-1:0][31:0] exp;
        int                  exp_done;
    } vec_t;

    vec_t        vecs[5];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] model[NS];
    logic [31:0] snap[NS];
    int          acc_cyc, acc_gap, busy_gap, n_acc, done_rel, done_cnt;
    int          ce_cnt, first_ce, bad_pat, busy;
    logic        done_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle and shifts the model SRLs like real hardware
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.upd_valid && bus.upd_ready) begin
                if (n_acc > 0) begin
                    acc_gap  = cyc - acc_cyc;
                    busy_gap = busy;
                end
                acc_cyc = cyc;
                n_acc++;
            end
            if (!bus.upd_ready) busy++;
            if (bus.srl_ce != '0) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = cyc - acc_cyc;
                if (!($onehot(bus.srl_ce) || (bus.srl_ce == '1 && bus.srl_d == 1'b0))) bad_pat++;
                for (int s = 0; s < NS; s++)
                    if (bus.srl_ce[s]) model[s] = {model[s][30:0], bus.srl_d};
            end
            if (bus.upd_done) begin
                if (bus.srl_ce != '0 || bus.srl_d != 1'b0) bad_pat++;
                done_rel  = cyc - acc_cyc;
                done_seen = 1'b1;
                done_cnt++;
                for (int s = 0; s < NS; s++) snap[s] = model[s];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Address a holds a one iff every unmasked address bit equals the key bit
    function automatic logic [31:0] ref_slice(input logic [4:0] k, input logic [4:0] m);
        logic [31:0] r;
        logic [4:0]  a5;
        r = '0;
        for (int a = 0; a < 32; a++) begin
            a5 = a[4:0];
            r[a] = ((a5 & ~m) == (k & ~m));
        end
        return r;
    endfunction

    function automatic logic [KW-1:0] rand_kw();
        return KW'({$urandom(), $urandom()});
    endfunction

    task automatic clear_stats();
        ce_cnt = 0; first_ce = -1; bad_pat = 0; busy = 0;
        done_seen = 1'b0; done_cnt = 0; n_acc = 0; done_rel = -1; acc_gap = -1; busy_gap = -1;
    endtask

    task automatic start_rule(input logic op, input logic [KW-1:0] key, input logic [KW-1:0] mask);
        int t;
        @(posedge clk); #1;
        clear_stats();
        bus.upd_valid = 1'b1; bus.upd_op = op; bus.upd_key = key; bus.upd_mask = mask;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.upd_ready && t < 600);
        @(posedge clk); #1;
    endtask

    task automatic finish_rule();
        int t;
        bus.upd_valid = 1'b0;
        bus.upd_key = rand_kw(); bus.upd_mask = rand_kw(); bus.upd_op = 1'($urandom());
        t = 0;
        while (!done_seen && t < 600) begin @(posedge clk); t++; end
        #1;
        check("done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic check_rule(input string tag, input logic op, input logic [KW-1:0] key,
                              input logic [KW-1:0] mask, input logic [NS-1:0][31:0] exp,
                              input int exp_done);
        check({tag, "_done_cycle"}, done_rel, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_ce_cycles"}, ce_cnt, op ? 32 : 32 * NS);
        check({tag, "_first_ce"}, first_ce, 1);
        check({tag, "_ce_pattern"}, bad_pat, 0);
        check({tag, "_busy_cycles"}, busy, exp_done);
        check({tag, "_ready_after"}, 32'(bus.upd_ready), 32'd1);
        for (int s = 0; s < NS; s++)
            check($sformatf("%s_slice%0d", tag, s), model[s], exp[s]);
    endtask

    initial begin
        logic [KW-1:0]       k, m, ka, ma, kb, mb;
        logic [NS-1:0][31:0] e;
        logic                op;
        int                  t;

        bus.upd_valid = 1'b0; bus.upd_op = 1'b0; bus.upd_key = '0; bus.upd_mask = '0;
        rst = 1'b1;
        for (int s = 0; s < NS; s++) model[s] = '0;
        clear_stats();

        // Directed table
        vecs[0].op = 1'b0; vecs[0].key = '0; vecs[0].mask = '0;
        for (int s = 0; s < NS; s++) e[s] = 32'h0000_0001;
        vecs[0].exp = e; vecs[0].exp_done = 257;

        k = '0; m = {NS{5'h1F}};
        k[19:15] = 5'h15; m[19:15] = 5'h03;
        for (int s = 0; s < NS; s++) e[s] = 32'hFFFF_FFFF;
        e[3] = 32'h00F0_0000;
        vecs[1].op = 1'b0; vecs[1].key = k; vecs[1].mask = m; vecs[1].exp = e; vecs[1].exp_done = 257;

        for (int s = 0; s < NS; s++) e[s] = 32'h0;
        vecs[2].op = 1'b1; vecs[2].key = rand_kw(); vecs[2].mask = rand_kw();
        vecs[2].exp = e; vecs[2].exp_done = 33;

        for (int s = 0; s < NS; s++) e[s] = 32'h8000_0000;
        vecs[3].op = 1'b0; vecs[3].key = {NS{5'h1F}}; vecs[3].mask = '0;
        vecs[3].exp = e; vecs[3].exp_done = 257;

        k = '0; m = {NS{5'h10}};
        k[4:0] = 5'h1E; m[4:0] = 5'h1E;
        for (int s = 0; s < NS; s++) e[s] = 32'h0001_0001;
        e[0] = 32'h5555_5555;
        vecs[4].op = 1'b0; vecs[4].key = k; vecs[4].mask = m; vecs[4].exp = e; vecs[4].exp_done = 257;

        // Reset values
        #12;
        check("rst_ready", 32'(bus.upd_ready), 32'd1);
        check("rst_ce", 32'(bus.srl_ce), 32'd0);
        check("rst_d", 32'(bus.srl_d), 32'd0);
        check("rst_done", 32'(bus.upd_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start_rule(vecs[i].op, vecs[i].key, vecs[i].mask);
            finish_rule();
            check_rule($sformatf("vec%0d", i), vecs[i].op, vecs[i].key, vecs[i].mask,
                       vecs[i].exp, vecs[i].exp_done);
        end

        // Reset in the middle of a LOAD, at cycle 100
        start_rule(1'b0, rand_kw(), rand_kw());
        repeat (99) @(posedge clk);
        #2;
        check("pre_rst_ce_onehot", 32'($onehot(bus.srl_ce)), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ce", 32'(bus.srl_ce), 32'd0);
        check("midrst_ready", 32'(bus.upd_ready), 32'd1);
        check("midrst_done", 32'(bus.upd_done), 32'd0);
        check("midrst_d", 32'(bus.srl_d), 32'd0);
        bus.upd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        k = rand_kw(); m = rand_kw();
        for (int s = 0; s < NS; s++) e[s] = ref_slice(k[5*s +: 5], m[5*s +: 5]);
        start_rule(1'b0, k, m);
        finish_rule();
        check_rule("after_rst", 1'b0, k, m, e, 257);

        // Randomized rules against the reference
        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 3) == 0);
            k = rand_kw();
            m = rand_kw() & rand_kw();
            for (int s = 0; s < NS; s++) e[s] = op ? 32'h0 : ref_slice(k[5*s +: 5], m[5*s +: 5]);
            start_rule(op, k, m);
            finish_rule();
            check_rule($sformatf("rnd%0d", i), op, k, m, e, op ? 33 : 257);
        end

        // Back-to-back with upd_valid held high; inputs switch to rule B during rule A's LOAD
        ka = rand_kw(); ma = rand_kw() & rand_kw();
        kb = rand_kw(); mb = rand_kw() & rand_kw();
        start_rule(1'b0, ka, ma);
        bus.upd_key = kb; bus.upd_mask = mb;
        t = 0;
        while (n_acc < 2 && t < 700) begin @(posedge clk); t++; end
        #1;
        bus.upd_valid = 1'b0;
        check("b2b_accept_gap", acc_gap, 258);
        check("b2b_busy_first", busy_gap, 257);
        for (int s = 0; s < NS; s++)
            check($sformatf("b2b_ruleA_slice%0d", s), snap[s], ref_slice(ka[5*s +: 5], ma[5*s +: 5]));
        done_seen = 1'b0;
        t = 0;
        while (!done_seen && t < 600) begin @(posedge clk); t++; end
        #1;
        check("b2b_second_done", 32'(done_seen), 32'd1);
        for (int s = 0; s < NS; s++)
            check($sformatf("b2b_ruleB_slice%0d", s), model[s], ref_slice(kb[5*s +: 5], mb[5*s +: 5]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
